// File: rtl/icache_fetch_if.sv
// Fetch-side and instruction-memory-side signals of icache_fetch.
// The cache uses the slave modport; the fetch stage / memory side uses master.
interface icache_fetch_if;
    // Fetch side: the address must stay stable while iCacheStall is high.
    logic [31:0]  Instr_address_2IM;
    logic         fetch_req;
    logic         invalidate;
    logic [31:0]  Instr1_fIM;
    logic [31:0]  Instr2_fIM;
    logic         single_fetch;
    logic         instr_valid;
    logic         iCacheStall;
    // Memory side: iBlkRead is the valid half of the handshake. It stays high with
    // iBlk_address stable until the rising edge that samples iBlkReady = 1.
    // That edge is the transfer, and block_read_fIM is captured on it.
    logic         iBlkRead;
    logic [31:0]  iBlk_address;
    logic [255:0] block_read_fIM;
    logic         iBlkReady;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
    logic         fsm_wait;

    modport slave (
        input  Instr_address_2IM, fetch_req, invalidate, block_read_fIM, iBlkReady,
        output Instr1_fIM, Instr2_fIM, single_fetch, instr_valid, iCacheStall,
        output iBlkRead, iBlk_address, hit_count, miss_count, fsm_wait
    );

    modport master (
        output Instr_address_2IM, fetch_req, invalidate, block_read_fIM, iBlkReady,
        input  Instr1_fIM, Instr2_fIM, single_fetch, instr_valid, iCacheStall,
        input  iBlkRead, iBlk_address, hit_count, miss_count, fsm_wait
    );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with dual-word fetch and 8-word line fill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_fetch #(
    parameter int NUM_LINES = 16
) (
    input logic         CLK,
    input logic         RESET,
    icache_fetch_if.slave bus
);
    localparam int IDXW = $clog2(NUM_LINES);
    localparam int TAGW = 27 - IDXW;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e               state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAGW-1:0]      tag_q  [NUM_LINES];
    logic [255:0]         data_q [NUM_LINES];
    logic [26:0]          miss_blk_q;
    logic                 poison_q;
    logic                 iblk_read_q;

    logic [2:0]      off;
    logic [2:0]      off_nxt;
    logic [IDXW-1:0] idx;
    logic [TAGW-1:0] tag;
    logic [IDXW-1:0] fill_idx;
    logic [TAGW-1:0] fill_tag;
    logic            hit_w;
    logic            miss_w;
    logic            fill_w;
    logic [255:0]    rd_line;
    logic            unused_ok;

    assign off      = bus.Instr_address_2IM[4:2];
    assign off_nxt  = off + 3'd1;
    assign idx      = bus.Instr_address_2IM[4+IDXW:5];
    assign tag      = bus.Instr_address_2IM[31:5+IDXW];
    assign fill_idx = miss_blk_q[IDXW-1:0];
    assign fill_tag = miss_blk_q[26:IDXW];
    assign unused_ok = &{1'b0, bus.Instr_address_2IM[1:0]};

    assign hit_w  = (state_q == S_IDLE) && bus.fetch_req && valid_q[idx] && (tag_q[idx] == tag);
    assign miss_w = (state_q == S_IDLE) && bus.fetch_req && !hit_w;
    assign fill_w = (state_q == S_WAIT) && bus.iBlkReady;

    // Word offset 7 has no successor inside the line, so only one word is delivered.
    always_comb begin
        rd_line           = data_q[idx];
        bus.Instr1_fIM    = '0;
        bus.Instr2_fIM    = '0;
        bus.single_fetch  = 1'b0;
        bus.instr_valid   = 1'b0;
        if (hit_w) begin
            bus.instr_valid  = 1'b1;
            bus.Instr1_fIM   = rd_line[{off, 5'b0} +: 32];
            bus.single_fetch = (off == 3'd7);
            if (off != 3'd7) begin
                bus.Instr2_fIM = rd_line[{off_nxt, 5'b0} +: 32];
            end
        end
    end

    assign bus.iCacheStall  = (state_q == S_WAIT) || miss_w;
    assign bus.iBlkRead     = iblk_read_q;
    assign bus.iBlk_address = {miss_blk_q, 5'b0};
    assign bus.fsm_wait     = (state_q == S_WAIT);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            miss_blk_q  <= '0;
            poison_q    <= 1'b0;
            iblk_read_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (miss_w) begin
                        state_q     <= S_WAIT;
                        miss_blk_q  <= bus.Instr_address_2IM[31:5];
                        poison_q    <= 1'b0;
                        iblk_read_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.iBlkReady) begin
                        state_q     <= S_IDLE;
                        poison_q    <= 1'b0;
                        iblk_read_q <= 1'b0;
                    end else if (bus.invalidate) begin
                        poison_q    <= 1'b1;
                    end
                end
            endcase
            // Invalidate on the fill edge also wipes the line being written.
            if (bus.invalidate) begin
                valid_q <= '0;
            end else if (fill_w) begin
                valid_q[fill_idx] <= !poison_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_w) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.block_read_fIM;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_w)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_w) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
`else
    assign bus.hit_count  = '0;
    assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_icache_fetch.sv
// Directed and randomized fetch sequences against a line-level cache model
// and a word-addressed memory model.
module tb_icache_fetch;
    localparam int NL = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    icache_fetch_if bus();
    icache_fetch #(.NUM_LINES(NL)) dut (.CLK(clk), .RESET(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] line_blk [NL];
    bit          line_ok  [NL];
    int          exp_hits;
    int          exp_misses;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] blk);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_rd(blk + 32'(4*i));
        return l;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) line_ok[i] = 1'b0;
    endtask

    task automatic check_counters(input string tag);
`ifdef ICACHE_STATS_EN
        chk({tag, "_hit_count"},  bus.hit_count,  32'(exp_hits));
        chk({tag, "_miss_count"}, bus.miss_count, 32'(exp_misses));
`else
        chk({tag, "_hit_count"},  bus.hit_count,  32'd0);
        chk({tag, "_miss_count"}, bus.miss_count, 32'd0);
`endif
    endtask

    // One fetch request held until the cache returns it; inv_k pulses invalidate
    // in that WAIT cycle of the first fill (-1: never).
    task automatic fetch(input logic [31:0] addr, input int delay, input int inv_k);
        logic [31:0] blk;
        int          idx;
        logic [2:0]  off;
        bit          hit;
        bit          done;
        bit          poisoned;
        logic [31:0] e1;
        logic [31:0] e2;
        blk  = addr & 32'hFFFF_FFE0;
        idx  = int'((addr >> 5) % NL);
        off  = addr[4:2];
        done = 1'b0;
        for (int it = 0; it < 3 && !done; it++) begin
            bus.Instr_address_2IM = addr;
            bus.fetch_req  = 1'b1;
            bus.iBlkReady  = 1'b0;
            bus.invalidate = 1'b0;
            @(negedge clk);
            hit = line_ok[idx] && (line_blk[idx] == blk);
            chk("instr_valid", 32'(bus.instr_valid), 32'(hit));
            chk("stall", 32'(bus.iCacheStall), 32'(!hit));
            chk("iBlkRead_idle", 32'(bus.iBlkRead), 32'd0);
            if (hit) begin
                e1 = mem_rd(blk + {27'd0, off, 2'b00});
                e2 = (off == 3'd7) ? 32'd0 : mem_rd(blk + {27'd0, off + 3'd1, 2'b00});
                chk("Instr1", bus.Instr1_fIM, e1);
                chk("Instr2", bus.Instr2_fIM, e2);
                chk("single_fetch", 32'(bus.single_fetch), 32'(off == 3'd7));
                exp_hits++;
                done = 1'b1;
                @(posedge clk); #1;
                bus.fetch_req = 1'b0;
            end else begin
                exp_misses++;
                exp_q.push_back(blk);
                poisoned = 1'b0;
                @(posedge clk); #1;
                for (int k = 0; k <= delay; k++) begin
                    bus.iBlkReady      = (k == delay);
                    bus.block_read_fIM = (k == delay) ? line_of(blk) : {8{$urandom}};
                    bus.invalidate     = (k == inv_k) && (it == 0);
                    @(negedge clk);
                    chk("iBlkRead", 32'(bus.iBlkRead), 32'd1);
                    chk("iBlk_address", bus.iBlk_address, exp_q[0]);
                    chk("stall_wait", 32'(bus.iCacheStall), 32'd1);
                    chk("valid_wait", 32'(bus.instr_valid), 32'd0);
                    chk("Instr1_wait", bus.Instr1_fIM, 32'd0);
                    chk("fsm_wait", 32'(bus.fsm_wait), 32'd1);
                    if (bus.invalidate) begin
                        poisoned = 1'b1;
                        model_clear();
                    end
                    @(posedge clk); #1;
                end
                void'(exp_q.pop_front());
                bus.iBlkReady  = 1'b0;
                bus.invalidate = 1'b0;
                line_blk[idx]  = blk;
                line_ok[idx]   = !poisoned;
            end
        end
    endtask

    task automatic do_inv();
        bus.fetch_req  = 1'b0;
        bus.invalidate = 1'b1;
        @(negedge clk);
        chk("inv_stall", 32'(bus.iCacheStall), 32'd0);
        chk("inv_valid", 32'(bus.instr_valid), 32'd0);
        @(posedge clk); #1;
        bus.invalidate = 1'b0;
        model_clear();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_iBlkRead"},     32'(bus.iBlkRead), 32'd0);
        chk({tag, "_iBlk_address"}, bus.iBlk_address, 32'd0);
        chk({tag, "_stall"},        32'(bus.iCacheStall), 32'd0);
        chk({tag, "_instr_valid"},  32'(bus.instr_valid), 32'd0);
        chk({tag, "_Instr1"},       bus.Instr1_fIM, 32'd0);
        chk({tag, "_Instr2"},       bus.Instr2_fIM, 32'd0);
        chk({tag, "_single"},       32'(bus.single_fetch), 32'd0);
        chk({tag, "_hit_count"},    bus.hit_count, 32'd0);
        chk({tag, "_miss_count"},   bus.miss_count, 32'd0);
    endtask

    task automatic reset_in_wait(input logic [31:0] addr);
        do_inv();
        bus.Instr_address_2IM = addr;
        bus.fetch_req = 1'b1;
        bus.iBlkReady = 1'b0;
        @(negedge clk);
        chk("rw_miss_stall", 32'(bus.iCacheStall), 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rw_iBlkRead", 32'(bus.iBlkRead), 32'd1);
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        #1 rst = 1'b1;
        bus.fetch_req = 1'b0;
        #1;
        check_reset_outputs("rw");
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] a;
        int          d;
        int          ik;
        bus.Instr_address_2IM = '0;
        bus.fetch_req      = 1'b0;
        bus.invalidate     = 1'b0;
        bus.block_read_fIM = '0;
        bus.iBlkReady      = 1'b0;
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) mem[32'h40 + 32'(4*i)] = 32'h1000 + 32'(i);
        fetch(32'h0000_0040, 0, -1);
        fetch(32'h0000_0044, 0, -1);
        fetch(32'h0000_005C, 0, -1);
        fetch(32'h0000_0240, 0, -1);
        fetch(32'h0000_0040, 0, -1);
        fetch(32'h0000_1008, 5, -1);
        fetch(32'h0000_2010, 3, 1);
        fetch(32'h0000_2014, 2, 2);
        do_inv();
        fetch(32'h0000_1000, 1, -1);
        fetch(32'h0000_0058, 0, -1);
        check_counters("directed");

        for (int n = 0; n < 80; n++) begin
            a = {21'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            d  = $urandom_range(0, 3);
            ik = ($urandom_range(0, 9) == 0) ? $urandom_range(0, d) : -1;
            fetch(a, d, ik);
            if ($urandom_range(0, 19) == 0) do_inv();
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        check_counters("random");

        reset_in_wait(32'h0000_0300);
        fetch(32'h0000_0300, 0, -1);
        chk("rw_refill_line", line_ok[(32'h300 >> 5) % NL] ? 32'd1 : 32'd0, 32'd1);
        fetch(32'h0000_0304, 0, -1);
        fetch(32'h0000_0308, 0, -1);
        check_counters("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/icache_fetch.md
# icache_fetch

Direct-mapped instruction cache between the pipelined MIPS fetch stage and instruction memory. Each cycle it returns the instruction at the fetch address plus the following word for dual fetch. On a miss it stalls the fetch stage and fills one 256-bit (8-word) line from memory over the iBlkRead / block_read_fIM path.

## Interface
Parameters:
- NUM_LINES, 16, number of lines; power of two, at least 2. IDXW = log2(NUM_LINES); tag width = 27 − IDXW.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- Instr_address_2IM  in  32  byte fetch address from IF. Bits [1:0] are ignored; offset = [4:2]; index = [4+IDXW:5]; tag = [31:5+IDXW].
- fetch_req  in  1  IF requests instructions this cycle.
- invalidate  in  1  clears every valid bit.
- Instr1_fIM  out  32  word at the fetch address.
- Instr2_fIM  out  32  word at fetch address + 4.
- single_fetch  out  1  only Instr1_fIM is valid (offset == 7).
- instr_valid  out  1  Instr1_fIM (and Instr2_fIM unless single_fetch) is valid this cycle.
- iCacheStall  out  1  freeze request to IF.
- iBlkRead  out  1  line-fill request to instruction memory.
- iBlk_address  out  32  block-aligned fill address; bits [4:0] = 0.
- block_read_fIM  in  256  fill data; word i is in bits [32i+31:32i].
- iBlkReady  in  1  fill data valid; sampled on the rising edge.
- hit_count  out  32  hit counter (see Configuration).
- miss_count  out  32  miss counter (see Configuration).

## Operation
- Storage: per line, a valid bit, a tag and 8 data words. Reads are combinational; writes are synchronous.
- FSM states:
  - IDLE
    - hit = fetch_req && valid[index] && tag match.
    - On a hit: instr_valid = 1 and data is driven combinationally.
    - On fetch_req && !hit: iCacheStall = 1, the block address is latched into a miss register, and the FSM goes to WAIT.
  - WAIT
    - iBlkRead = 1, iBlk_address = miss register, iCacheStall = 1, instr_valid = 0.
    - On the edge where iBlkReady = 1: write the line (data, tag, valid = 1 unless poisoned) and go to IDLE.
- Dual fetch: Instr2_fIM = word[offset+1] of the same line.
  - At offset 7: single_fetch = 1 and Instr2_fIM = 0 (NOP). No cross-line fetch.
- When instr_valid = 0, Instr1_fIM = Instr2_fIM = 0 and single_fetch = 0.
- Invalidate:
  - In IDLE: all valid bits are cleared at the edge. A lookup in the same cycle still uses the old valid bits.
  - In WAIT: a poison flag is set; the in-flight fill writes its data and tag with valid = 0, so the next lookup misses again.
  - Simultaneous with the fill edge: all lines are cleared, the filled line included.
- The fetch address must be held stable while iCacheStall = 1. If fetch_req drops during WAIT, the fill still completes; there is no abort.

## Timing
- Hit: zero-cycle (combinational) response in the request cycle.
- Miss with memory delay of d cycles (iBlkReady high in the (d+1)th WAIT cycle):
  - request cycle 0 misses;
  - WAIT lasts d+1 cycles;
  - the hit is returned in cycle d+2.
- Minimum miss penalty: 2 cycles.
- iBlkRead rises in cycle 1, after the miss edge, and falls on the edge that samples iBlkReady.
- Reset values:
  - FSM = IDLE, all valid bits = 0, poison = 0, miss register = 0, counters = 0.
  - iBlkRead = 0, iBlk_address = 0, iCacheStall = 0, instr_valid = 0.
  - Instr1_fIM = Instr2_fIM = 0, single_fetch = 0.
- RESET asserted during WAIT: the fill is abandoned immediately and iBlkRead drops asynchronously.

## Configuration
- Macro: ICACHE_STATS_EN.
- Defined:
  - hit_count increments once per IDLE cycle with a hit.
  - miss_count increments on each IDLE→WAIT transition.
  - Both counters wrap at 2^32 and are cleared by RESET only.
- Undefined: no counters are built; hit_count and miss_count are tied to 0.

## Test plan
- Cold miss: after reset, fetch address 0x00000040 with memory word i = 0x1000+i and iBlkReady in the first WAIT cycle -> stall cycles 0–1, iBlkRead with iBlk_address = 0x40 in cycle 1, then in cycle 2 Instr1 = 0x1000, Instr2 = 0x1001, instr_valid = 1.
- Same-line hits: fetch 0x44 and then 0x5C with no stall -> first gives 0x1001 / 0x1002; 0x5C gives 0x1007, single_fetch = 1, Instr2 = 0.
- Conflict: with NUM_LINES = 16, fetch 0x40 and then 0x240 (same index, different tag) -> miss and refill. Fetching 0x40 again misses again.
- Slow memory: iBlkReady delayed 5 cycles -> iBlkRead held for 6 cycles, hit in cycle 7, iBlk_address stable throughout.
- Invalidate:
  - pulsed during WAIT -> the fill completes but the next lookup misses;
  - pulsed in IDLE after fills -> all lines miss.
- Reset in WAIT: RESET asserted in the 3rd WAIT cycle -> iBlkRead = 0 at once, all lines invalid. Under ICACHE_STATS_EN, counters read 0; after 1 miss and 3 hits, miss_count = 1 and hit_count = 3.
